// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: memory geometry,
// loader FSM state encodings and a PC helper.
package imem_loader_pkg;

  // Instruction memory depth in words and the matching word-address width.
  localparam int IMEM_SIZE      = 256;
  localparam int AW             = 8;

  // Stream bytes that make up one instruction word.
  localparam int BYTES_PER_WORD = 4;

  // Loader FSM state encodings.
  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_ASM   = 3'd1;
  localparam logic [2:0] LD_SETPC = 3'd2;
  localparam logic [2:0] LD_WRITE = 3'd3;
  localparam logic [2:0] LD_BOOT  = 3'd4;

  // Byte address presented to IF for a given word index.
  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] widx);
    return {widx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word assembler: shifts accepted stream bytes in MSB first and
// flags the beat that completes a 32-bit instruction word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        srst,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Only the three most recent bytes need storing; the fourth arrives on the
  // completing beat and is merged combinationally into word_nxt.
  logic [1:0]  cnt_r;
  logic [23:0] shift_r;

  // Shift one byte per accepted beat and count beats within the current word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (srst) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (shift_en) begin
      shift_r <= word_nxt[23:0];
      // Wraps back to 0 after the last byte of a word.
      cnt_r   <= cnt_r + 2'd1;
    end
  end

  // Word as it stands including this beat; valid on the last beat of a word.
  always_comb begin
    word_nxt   = {shift_r, byte_in};
    word_valid = shift_en && (cnt_r == LAST_BYTE);
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Assembles a byte stream into 32-bit
// words and steers IF's newPC/WE/W_Ins so word k lands at IMem[k]. Each write
// is preceded by a PC setup cycle because IF writes IMem[PC>>2] with the PC
// latched on the previous edge. A final BOOT cycle holds IF in reset so the
// CPU restarts from PC 0.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_SIZE = imem_loader_pkg::IMEM_SIZE,
  parameter int AW        = imem_loader_pkg::AW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          if_rst,
  output logic          pc_sel,
  output logic [31:0]   if_newpc,
  output logic          if_we,
  output logic [31:0]   if_w_ins,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Length and index use AW+1 bits so a full-memory load needs no wrap.
  localparam logic [AW:0] MAX_LEN = (AW+1)'(IMEM_SIZE);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_W  = (AW+1)'(0);

  logic [2:0]  state_r;
  logic [2:0]  nxt_state_s;
  logic [AW:0] len_r;
  logic [AW:0] idx_r;

  logic        shift_en_s;
  logic        srst_s;
  logic        word_valid_s;
  logic [31:0] word_nxt_s;

  logic        len_bad_s;
  logic        accept_s;
  logic        last_word_s;

  logic        if_rst_nxt_s;
  logic        pc_sel_nxt_s;
  logic        we_nxt_s;
  logic        busy_nxt_s;
  logic        done_nxt_s;
  logic        err_nxt_s;
  logic [31:0] newpc_nxt_s;
  logic [31:0] w_ins_nxt_s;

  // Bytes are only taken while assembling; the source holds its byte otherwise.
  assign byte_ready = (state_r == LD_ASM);

  // Request qualification and last-word detection.
  always_comb begin
    shift_en_s  = byte_valid && byte_ready;
    srst_s      = (state_r == LD_IDLE);
    len_bad_s   = (load_len > MAX_LEN);
    accept_s    = (state_r == LD_IDLE) && start && !len_bad_s;
    last_word_s = (idx_r == (len_r - ONE_W));
  end

  byte_packer u_packer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .srst       (srst_s),
    .shift_en   (shift_en_s),
    .byte_in    (byte_data),
    .word_nxt   (word_nxt_s),
    .word_valid (word_valid_s)
  );

  // Next-state decode for the load sequence.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      LD_IDLE: begin
        if (start && !len_bad_s) begin
          if (load_len == ZERO_W) begin
            nxt_state_s = LD_BOOT;
          end else begin
            nxt_state_s = LD_ASM;
          end
        end else begin
          nxt_state_s = LD_IDLE;
        end
      end
      LD_ASM: begin
        if (word_valid_s) begin
          nxt_state_s = LD_SETPC;
        end else begin
          nxt_state_s = LD_ASM;
        end
      end
      LD_SETPC: begin
        nxt_state_s = LD_WRITE;
      end
      LD_WRITE: begin
        if (last_word_s) begin
          nxt_state_s = LD_BOOT;
        end else begin
          nxt_state_s = LD_ASM;
        end
      end
      LD_BOOT: begin
        nxt_state_s = LD_IDLE;
      end
      default: begin
        nxt_state_s = LD_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so registered outputs line up with it.
  always_comb begin
    if_rst_nxt_s = 1'b0;
    pc_sel_nxt_s = 1'b0;
    we_nxt_s     = 1'b0;
    busy_nxt_s   = 1'b0;
    newpc_nxt_s  = if_newpc;
    w_ins_nxt_s  = if_w_ins;
    case (nxt_state_s)
      LD_IDLE: begin
        // CPU runs from its own PC path.
        if_rst_nxt_s = 1'b0;
      end
      LD_ASM: begin
        // Hold IF in reset so nothing is written while bytes arrive.
        if_rst_nxt_s = 1'b1;
        pc_sel_nxt_s = 1'b1;
        busy_nxt_s   = 1'b1;
      end
      LD_SETPC: begin
        // Only reached from ASM on the completing beat, so word_nxt is the full word.
        pc_sel_nxt_s = 1'b1;
        busy_nxt_s   = 1'b1;
        newpc_nxt_s  = word_to_byte_addr(30'(idx_r));
        w_ins_nxt_s  = word_nxt_s;
      end
      LD_WRITE: begin
        // PC and data held from SETPC; IF writes at the end of this cycle.
        pc_sel_nxt_s = 1'b1;
        busy_nxt_s   = 1'b1;
        we_nxt_s     = 1'b1;
      end
      LD_BOOT: begin
        // One cycle of IF reset forces PC and nextPC to 0.
        if_rst_nxt_s = 1'b1;
        busy_nxt_s   = 1'b1;
        newpc_nxt_s  = 32'd0;
      end
      default: begin
        if_rst_nxt_s = 1'b1;
      end
    endcase
  end

  // Status pulses: err on a rejected start, done on the cycle after BOOT.
  always_comb begin
    err_nxt_s  = (state_r == LD_IDLE) && start && len_bad_s;
    done_nxt_s = (state_r == LD_BOOT);
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= LD_IDLE;
      if_rst   <= 1'b1;
      pc_sel   <= 1'b0;
      if_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if_newpc <= 32'd0;
      if_w_ins <= 32'd0;
    end else begin
      state_r  <= nxt_state_s;
      if_rst   <= if_rst_nxt_s;
      pc_sel   <= pc_sel_nxt_s;
      if_we    <= we_nxt_s;
      busy     <= busy_nxt_s;
      done     <= done_nxt_s;
      err      <= err_nxt_s;
      if_newpc <= newpc_nxt_s;
      if_w_ins <= w_ins_nxt_s;
    end
  end

  // Latched load length and word index; index advances after each write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_r <= ZERO_W;
      idx_r <= ZERO_W;
    end else if (accept_s) begin
      len_r <= load_len;
      idx_r <= ZERO_W;
    end else if ((state_r == LD_WRITE) && !last_word_s) begin
      idx_r <= idx_r + ONE_W;
    end
  end

endmodule
